// File: rtl/vpu_sram_rd_arbiter_pkg.sv
// Shared SRAM geometry for the VPU operand read path, plus a small width helper.
package vpu_sram_rd_arbiter_pkg;

    localparam int unsigned SRAM_BANK_CNT_LG2   = 2;
    localparam int unsigned SRAM_BANK_DEPTH_LG2 = 8;
    localparam int unsigned SRAM_DATA_WIDTH     = 256;
    localparam int unsigned SRAM_RD_LAT         = 1;
    localparam int unsigned SRAM_BANK_CNT       = 1 << SRAM_BANK_CNT_LG2;

    // Index width for a vector of n entries; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vpu_rr_arbiter.sv
// Round-robin arbiter: the winner is the first requester above the last winner, wrapping.
module vpu_rr_arbiter
    import vpu_sram_rd_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    localparam int unsigned IDX_W  = idx_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0] ptr;
    logic             any_grant;

    // Scan upward from ptr+1; the first live request wins.
    always_comb begin
        int unsigned idx;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (32'(ptr) + k) % NUM_REQ;
            if (!any_grant && req[IDX_W'(idx)]) begin
                any_grant             = 1'b1;
                grant[IDX_W'(idx)]    = 1'b1;
                grant_idx             = IDX_W'(idx);
            end
        end
    end

    // Reset to the top index so requester 0 is favoured first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= IDX_W'(NUM_REQ - 1);
        end else if (any_grant) begin
            ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/vpu_sram_rd_arbiter.sv
// Banked operand SRAM read arbiter: per-bank round-robin grant, bank drive,
// and a fixed-latency return path that steers bank data back to its requester.
module vpu_sram_rd_arbiter
    import vpu_sram_rd_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 3,
    parameter int unsigned BANK_CNT_LG2   = SRAM_BANK_CNT_LG2,
    parameter int unsigned BANK_DEPTH_LG2 = SRAM_BANK_DEPTH_LG2,
    parameter int unsigned DATA_WIDTH     = SRAM_DATA_WIDTH,
    parameter int unsigned RD_LAT         = SRAM_RD_LAT,
    localparam int unsigned BANK_CNT      = 1 << BANK_CNT_LG2,
    localparam int unsigned IDX_W         = idx_width(NUM_REQ)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 req_i,
    input  logic [NUM_REQ*BANK_CNT_LG2-1:0]    rid_i,
    input  logic [NUM_REQ*BANK_DEPTH_LG2-1:0]  addr_i,
    output logic [NUM_REQ-1:0]                 ack_o,
    output logic [NUM_REQ-1:0]                 rvalid_o,
    output logic [NUM_REQ*DATA_WIDTH-1:0]      rdata_o,
    output logic [BANK_CNT-1:0]                bank_reb_o,
    output logic [BANK_CNT*BANK_DEPTH_LG2-1:0] bank_addr_o,
    input  logic [BANK_CNT*DATA_WIDTH-1:0]     bank_rdata_i
);

    logic [BANK_CNT_LG2-1:0]   rid_a        [NUM_REQ];
    logic [BANK_DEPTH_LG2-1:0] addr_a       [NUM_REQ];
    logic [DATA_WIDTH-1:0]     bank_rdata_a [BANK_CNT];
    logic [NUM_REQ-1:0]        bank_gnt     [BANK_CNT];

    logic                      pipe_vld     [NUM_REQ][RD_LAT];
    logic [BANK_CNT_LG2-1:0]   pipe_bank    [NUM_REQ][RD_LAT];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        assign rid_a[i]  = rid_i[i*BANK_CNT_LG2 +: BANK_CNT_LG2];
        assign addr_a[i] = addr_i[i*BANK_DEPTH_LG2 +: BANK_DEPTH_LG2];
    end

    for (genvar b = 0; b < BANK_CNT; b++) begin : g_bank
        logic [NUM_REQ-1:0] req_v;
        logic [NUM_REQ-1:0] gnt_v;
        logic [IDX_W-1:0]   gnt_idx;

        // Only requesters addressing this bank compete; nothing competes under reset.
        always_comb begin
            req_v = '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                req_v[i] = rst_n & req_i[i] & (rid_a[i] == BANK_CNT_LG2'(b));
            end
        end

        vpu_rr_arbiter #(
            .NUM_REQ   (NUM_REQ)
        ) u_arb (
            .clk       (clk),
            .rst_n     (rst_n),
            .req       (req_v),
            .grant     (gnt_v),
            .grant_idx (gnt_idx)
        );

        assign bank_gnt[b]                                      = gnt_v;
        assign bank_rdata_a[b]                                  = bank_rdata_i[b*DATA_WIDTH +: DATA_WIDTH];
        assign bank_reb_o[b]                                    = ~|gnt_v;
        assign bank_addr_o[b*BANK_DEPTH_LG2 +: BANK_DEPTH_LG2]  = (|gnt_v) ? addr_a[gnt_idx] : '0;
    end

    // A requester targets a single bank, so OR-ing the per-bank grants keeps ack one-hot per bank.
    always_comb begin
        ack_o = '0;
        for (int unsigned b = 0; b < BANK_CNT; b++) begin
            ack_o = ack_o | bank_gnt[b];
        end
    end

    // Per-requester {valid, bank} delay line matching the SRAM read latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                for (int unsigned s = 0; s < RD_LAT; s++) begin
                    pipe_vld[i][s]  <= 1'b0;
                    pipe_bank[i][s] <= '0;
                end
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                pipe_vld[i][0]  <= ack_o[i];
                pipe_bank[i][0] <= rid_a[i];
                for (int unsigned s = 1; s < RD_LAT; s++) begin
                    pipe_vld[i][s]  <= pipe_vld[i][s-1];
                    pipe_bank[i][s] <= pipe_bank[i][s-1];
                end
            end
        end
    end

    // Steer the recorded bank's data to the requester; zero whenever not valid.
    always_comb begin
        rvalid_o = '0;
        rdata_o  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (rst_n && pipe_vld[i][RD_LAT-1]) begin
                rvalid_o[i]                          = 1'b1;
                rdata_o[i*DATA_WIDTH +: DATA_WIDTH]  = bank_rdata_a[pipe_bank[i][RD_LAT-1]];
            end
        end
    end

endmodule
